regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port between two writeback sources: ALU result and memory load return.

---
 rtl/rf_pkg.sv | 11 +
 rtl/regfile_wb_arbiter_if.sv | 26 ++
 rtl/rf_scoreboard.sv | 33 +++
 rtl/regfile_wb_arbiter.sv | 58 +++++
 tb/tb_regfile_wb_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared widths and types for the register-file writeback arbiter
package rf_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NREGS = 2 ** ADDR_W;
   typedef enum logic {SRC_ALU, SRC_MEM} src_e;
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback requests, issue-stage lookups and the register-file write port
interface regfile_wb_arbiter_if;
   import rf_pkg::*;
   logic              alu_valid, alu_ready;
   logic [ADDR_W-1:0] alu_waddr;
   logic [DATA_W-1:0] alu_wdata;
   logic              mem_valid, mem_ready;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              iss_valid;
   logic [ADDR_W-1:0] iss_waddr, rs_addr, rt_addr;
   logic              stall;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   modport master (
      output alu_valid, alu_waddr, alu_wdata, mem_valid, mem_waddr, mem_wdata,
             iss_valid, iss_waddr, rs_addr, rt_addr,
      input  alu_ready, mem_ready, stall, rf_we, rf_waddr, rf_wdata
   );
   modport slave (
      input  alu_valid, alu_waddr, alu_wdata, mem_valid, mem_waddr, mem_wdata,
             iss_valid, iss_waddr, rs_addr, rt_addr,
      output alu_ready, mem_ready, stall, rf_we, rf_waddr, rf_wdata
   );
endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: pending-write bits, set beats clear on the same register, r0 never pending
module rf_scoreboard import rf_pkg::*; (
   input  logic              clk,
   input  logic              rst,
   input  logic              set_en,
   input  logic [ADDR_W-1:0] set_addr,
   input  logic              clr_en,
   input  logic [ADDR_W-1:0] clr_addr,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   input  logic [ADDR_W-1:0] wa_addr,
   output logic              rs_pend,
   output logic              rt_pend,
   output logic              wa_pend
);
   logic [NREGS-1:0] pending, set_mask, clr_mask;
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      set_mask[set_addr] = set_en && set_addr != '0;
      clr_mask[clr_addr] = clr_en;
   end
   always_ff @(posedge clk)
      if (rst) pending <= '0;
      else pending <= (pending & ~clr_mask) | set_mask;
   assign rs_pend = pending[rs_addr];
   assign rt_pend = pending[rt_addr];
   assign wa_pend = pending[wa_addr];
`ifndef SYNTHESIS
   always_ff @(posedge clk)
      if (!rst && clr_en) assert (pending[clr_addr]) else $warning("writeback to non-pending r%0d", clr_addr);
`endif
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: ALU/load writeback arbiter with scoreboard; RFWB_ROUND_ROBIN_EN selects round-robin
module regfile_wb_arbiter import rf_pkg::*; #(
   parameter int STARVE_MAX = 3
) (
   input logic                 clk,
   input logic                 rst,
   regfile_wb_arbiter_if.slave bus
);
   logic    alu_gnt, mem_gnt, rs_pend, rt_pend, wa_pend;
   wb_req_t acc;
`ifdef RFWB_ROUND_ROBIN_EN
   src_e rr_last;
   assign alu_gnt = !rst && bus.alu_valid && (!bus.mem_valid || rr_last == SRC_MEM);
   always_ff @(posedge clk)
      if (rst) rr_last <= SRC_MEM;
      else if (alu_gnt) rr_last <= SRC_ALU;
      else if (mem_gnt) rr_last <= SRC_MEM;
`else
   localparam int CW = $clog2(STARVE_MAX + 1);
   logic [CW-1:0] starve_cnt;
   assign alu_gnt = !rst && bus.alu_valid && (!bus.mem_valid || starve_cnt == CW'(STARVE_MAX));
   always_ff @(posedge clk)
      if (rst || !bus.alu_valid || alu_gnt) starve_cnt <= '0;
      else if (starve_cnt != CW'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
`endif
   assign mem_gnt = !rst && bus.mem_valid && !alu_gnt;
   assign bus.alu_ready = alu_gnt;
   assign bus.mem_ready = mem_gnt;
   assign acc = alu_gnt ? {bus.alu_waddr, bus.alu_wdata} : {bus.mem_waddr, bus.mem_wdata};
   // r0 writes are accepted and latched but never enabled
   always_ff @(posedge clk)
      if (rst) begin
         bus.rf_we <= 1'b0;
         bus.rf_waddr <= '0;
         bus.rf_wdata <= '0;
      end else begin
         bus.rf_we <= (alu_gnt || mem_gnt) && acc.addr != '0;
         if (alu_gnt || mem_gnt) begin
            bus.rf_waddr <= acc.addr;
            bus.rf_wdata <= acc.data;
         end
      end
   rf_scoreboard u_sb (
      .clk(clk),
      .rst(rst),
      .set_en(bus.iss_valid && !bus.stall),
      .set_addr(bus.iss_waddr),
      .clr_en(bus.rf_we),
      .clr_addr(bus.rf_waddr),
      .rs_addr(bus.rs_addr),
      .rt_addr(bus.rt_addr),
      .wa_addr(bus.iss_waddr),
      .rs_pend(rs_pend),
      .rt_pend(rt_pend),
      .wa_pend(wa_pend)
   );
   assign bus.stall = rs_pend || rt_pend || (bus.iss_valid && wa_pend);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scenarios plus randomized traffic against a behavioural model
module tb_regfile_wb_arbiter;
   import rf_pkg::*;
   localparam int SMAX = 3;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int vectors = 0;
   int miscompares = 0;
   bit pend [NREGS];
   bit m_we;
   logic [ADDR_W-1:0] m_waddr;
   logic [DATA_W-1:0] m_wdata;
   int alu_wait;
   bit last_mem;
   regfile_wb_arbiter_if bus ();
   regfile_wb_arbiter #(.STARVE_MAX(SMAX)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   task automatic idle();
      bus.alu_valid = 1'b0; bus.alu_waddr = '0; bus.alu_wdata = '0;
      bus.mem_valid = 1'b0; bus.mem_waddr = '0; bus.mem_wdata = '0;
      bus.iss_valid = 1'b0; bus.iss_waddr = '0; bus.rs_addr = '0; bus.rt_addr = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      bus.alu_valid = 1'b1; bus.alu_waddr = 5'd3; bus.alu_wdata = '1;
      bus.mem_valid = 1'b1; bus.mem_waddr = 5'd4; bus.rs_addr = 5'd3;
      repeat (2) begin
         @(negedge clk); vectors++;
         if ({bus.alu_ready, bus.mem_ready, bus.stall, bus.rf_we} !== 4'b0000) begin
            miscompares++; $display("FAIL reset_ctrl: got %b want 0000", {bus.alu_ready, bus.mem_ready, bus.stall, bus.rf_we});
         end
      end
      @(posedge clk); #1;
      rst = 1'b0;
      idle();
      @(negedge clk); vectors++;
      if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.stall} !== 39'd0) begin
         miscompares++; $display("FAIL reset_regs: got we=%b a=%0d d=%h st=%b want all 0", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.stall);
      end
   endtask

   task automatic test_raw();
      @(posedge clk); #1;
      idle(); bus.iss_valid = 1'b1; bus.iss_waddr = 5'd5;
      @(negedge clk); vectors++;
      if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL raw_issue: got stall=%b want 0", bus.stall); end
      @(posedge clk); #1;
      idle(); bus.alu_valid = 1'b1; bus.alu_waddr = 5'd5; bus.alu_wdata = 32'h1234; bus.rs_addr = 5'd5;
      @(negedge clk); vectors++;
      if ({bus.alu_ready, bus.mem_ready, bus.stall} !== 3'b101) begin
         miscompares++; $display("FAIL raw_accept: got rdy_a/rdy_m/stall=%b want 101", {bus.alu_ready, bus.mem_ready, bus.stall});
      end
      @(posedge clk); #1;
      bus.alu_valid = 1'b0;
      @(negedge clk); vectors++;
      if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.stall} !== {1'b1, 5'd5, 32'h1234, 1'b1}) begin
         miscompares++; $display("FAIL raw_write: got we=%b a=%0d d=%h st=%b want 1 5 1234 1", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.stall);
      end
      @(posedge clk); #1;
      @(negedge clk); vectors++;
      if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.stall} !== {1'b0, 5'd5, 32'h1234, 1'b0}) begin
         miscompares++; $display("FAIL raw_release: got we=%b a=%0d d=%h st=%b want 0 5 1234 0", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.stall);
      end
   endtask

   task automatic test_waw();
      @(posedge clk); #1;
      idle(); bus.iss_valid = 1'b1; bus.iss_waddr = 5'd7;
      @(negedge clk); vectors++;
      if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL waw_first: got stall=%b want 0", bus.stall); end
      @(posedge clk); #1;
      @(negedge clk); vectors++;
      if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL waw_second: got stall=%b want 1", bus.stall); end
      @(posedge clk); #1;
      idle(); bus.mem_valid = 1'b1; bus.mem_waddr = 5'd7; bus.mem_wdata = 32'h77;
      @(negedge clk); vectors++;
      if ({bus.alu_ready, bus.mem_ready} !== 2'b01) begin
         miscompares++; $display("FAIL waw_accept: got rdy=%b want 01", {bus.alu_ready, bus.mem_ready});
      end
      @(posedge clk); #1;
      bus.mem_valid = 1'b0; bus.rs_addr = 5'd7;
      @(negedge clk); vectors++;
      if ({bus.rf_we, bus.stall} !== 2'b11) begin miscompares++; $display("FAIL waw_write: got we/stall=%b want 11", {bus.rf_we, bus.stall}); end
      @(posedge clk); #1;
      @(negedge clk); vectors++;
      if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL waw_release: got stall=%b want 0", bus.stall); end
   endtask

   task automatic test_priority();
      logic [1:0] exp_g [8];
      int ai, mi;
      logic [ADDR_W-1:0] prev;
`ifdef RFWB_ROUND_ROBIN_EN
      exp_g = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
`else
      exp_g = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10};
`endif
      do_reset();
      for (int r = 1; r <= 8; r++) begin
         idle(); bus.iss_valid = 1'b1; bus.iss_waddr = ADDR_W'(r);
         @(negedge clk); vectors++;
         if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL prio_issue r%0d: got stall=%b want 0", r, bus.stall); end
         @(posedge clk); #1;
      end
      ai = 1; mi = 5; prev = '0;
      for (int k = 0; k < 8; k++) begin
         idle();
         bus.alu_valid = ai <= 4; bus.alu_waddr = ADDR_W'(ai); bus.alu_wdata = 32'hA000 + ai;
         bus.mem_valid = mi <= 8; bus.mem_waddr = ADDR_W'(mi); bus.mem_wdata = 32'hB000 + mi;
         @(negedge clk); vectors++;
         if ({bus.alu_ready, bus.mem_ready} !== exp_g[k]) begin
            miscompares++; $display("FAIL prio_grant %0d: got rdy_a/rdy_m=%b want %b", k, {bus.alu_ready, bus.mem_ready}, exp_g[k]);
         end
         if (k > 0) begin
            vectors++;
            if ({bus.rf_we, bus.rf_waddr} !== {1'b1, prev}) begin
               miscompares++; $display("FAIL prio_write %0d: got we=%b a=%0d want 1 %0d", k, bus.rf_we, bus.rf_waddr, prev);
            end
         end
         if (exp_g[k][1]) begin prev = ADDR_W'(ai); ai++; end
         else begin prev = ADDR_W'(mi); mi++; end
         @(posedge clk); #1;
      end
      idle();
      @(negedge clk); vectors++;
      if ({bus.rf_we, bus.rf_waddr} !== {1'b1, prev}) begin
         miscompares++; $display("FAIL prio_last: got we=%b a=%0d want 1 %0d", bus.rf_we, bus.rf_waddr, prev);
      end
      @(posedge clk); #1;
      for (int r = 1; r <= 8; r++) begin
         bus.rs_addr = ADDR_W'(r);
         #1; vectors++;
         if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL prio_drain r%0d: got stall=%b want 0", r, bus.stall); end
      end
   endtask

   task automatic test_r0();
      @(posedge clk); #1;
      idle(); bus.alu_valid = 1'b1; bus.alu_waddr = '0; bus.alu_wdata = 32'hFFFF_FFFF;
      @(negedge clk); vectors++;
      if (bus.alu_ready !== 1'b1) begin miscompares++; $display("FAIL r0_accept: got rdy=%b want 1", bus.alu_ready); end
      @(posedge clk); #1;
      idle(); bus.iss_valid = 1'b1; bus.iss_waddr = '0;
      @(negedge clk); vectors++;
      if ({bus.rf_we, bus.stall} !== 2'b00) begin miscompares++; $display("FAIL r0_write: got we/stall=%b want 00", {bus.rf_we, bus.stall}); end
      @(posedge clk); #1;
      @(negedge clk); vectors++;
      if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL r0_reissue: got stall=%b want 0", bus.stall); end
   endtask

   task automatic test_setclr_reset();
      @(posedge clk); #1;
      idle(); bus.alu_valid = 1'b1; bus.alu_waddr = 5'd9; bus.alu_wdata = 32'h99;
      @(negedge clk); vectors++;
      if (bus.alu_ready !== 1'b1) begin miscompares++; $display("FAIL setclr_accept: got rdy=%b want 1", bus.alu_ready); end
      @(posedge clk); #1;
      idle(); bus.iss_valid = 1'b1; bus.iss_waddr = 5'd9;
      @(negedge clk); vectors++;
      if ({bus.rf_we, bus.rf_waddr, bus.stall} !== {1'b1, 5'd9, 1'b0}) begin
         miscompares++; $display("FAIL setclr_same: got we=%b a=%0d st=%b want 1 9 0", bus.rf_we, bus.rf_waddr, bus.stall);
      end
      @(posedge clk); #1;
      idle(); bus.rs_addr = 5'd9;
      @(negedge clk); vectors++;
      if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL setclr_wins: got stall=%b want 1", bus.stall); end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk); vectors++;
      if ({bus.stall, bus.rf_we} !== 2'b00) begin miscompares++; $display("FAIL mid_reset: got stall/we=%b want 00", {bus.stall, bus.rf_we}); end
   endtask

   function automatic logic [ADDR_W-1:0] pick(input bit ov, input logic [ADDR_W-1:0] oa);
      logic [ADDR_W-1:0] r;
      r = ADDR_W'($urandom_range(1, 7));
      if (!pend[r] || (ov && oa == r) || (m_we && m_waddr == r)) r = '0;
      return r;
   endfunction

   task automatic test_random();
      bit eg_a, eg_m, es;
      do_reset();
      foreach (pend[i]) pend[i] = 1'b0;
      m_we = 1'b0; m_waddr = '0; m_wdata = '0; alu_wait = 0; last_mem = 1'b1;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
`ifdef RFWB_ROUND_ROBIN_EN
         eg_a = bus.alu_valid && (!bus.mem_valid || last_mem);
`else
         eg_a = bus.alu_valid && (!bus.mem_valid || alu_wait == SMAX);
`endif
         eg_m = bus.mem_valid && !eg_a;
         es = pend[bus.rs_addr] || pend[bus.rt_addr] || (bus.iss_valid && pend[bus.iss_waddr]);
         vectors++;
         if ({bus.alu_ready, bus.mem_ready, bus.stall} !== {eg_a, eg_m, es}) begin
            miscompares++; $display("FAIL rand_ctrl %0d: got rdy_a/rdy_m/stall=%b want %b", c, {bus.alu_ready, bus.mem_ready, bus.stall}, {eg_a, eg_m, es});
         end
         vectors++;
         if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {m_we, m_waddr, m_wdata}) begin
            miscompares++; $display("FAIL rand_write %0d: got we=%b a=%0d d=%h want %b %0d %h", c, bus.rf_we, bus.rf_waddr, bus.rf_wdata, m_we, m_waddr, m_wdata);
         end
         if (m_we) pend[m_waddr] = 1'b0;
         if (bus.iss_valid && !es && bus.iss_waddr != '0) pend[bus.iss_waddr] = 1'b1;
         if (eg_a || eg_m) begin
            m_waddr = eg_a ? bus.alu_waddr : bus.mem_waddr;
            m_wdata = eg_a ? bus.alu_wdata : bus.mem_wdata;
            m_we = m_waddr != '0;
         end else m_we = 1'b0;
         alu_wait = (bus.alu_valid && !eg_a) ? ((alu_wait < SMAX) ? alu_wait + 1 : SMAX) : 0;
         if (eg_a) last_mem = 1'b0;
         else if (eg_m) last_mem = 1'b1;
         @(posedge clk); #1;
         if (!bus.alu_valid || eg_a) begin
            bus.alu_waddr = pick(bus.mem_valid && !eg_m, bus.mem_waddr);
            bus.alu_valid = 1'($urandom_range(0, 1));
            bus.alu_wdata = $urandom;
         end
         if (!bus.mem_valid || eg_m) begin
            bus.mem_waddr = pick(bus.alu_valid, bus.alu_waddr);
            bus.mem_valid = 1'($urandom_range(0, 1));
            bus.mem_wdata = $urandom;
         end
         bus.iss_valid = $urandom_range(0, 2) == 0;
         bus.iss_waddr = ADDR_W'($urandom_range(0, 7));
         bus.rs_addr = ADDR_W'($urandom_range(0, 15));
         bus.rt_addr = ADDR_W'($urandom_range(0, 15));
      end
   endtask

   initial begin
      test_reset();
      test_raw();
      test_waw();
      test_priority();
      test_r0();
      test_setclr_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
